// File: rtl/cpu_mul_pkg.sv
// Shared CPU multiply definitions: op encodings, sequencer states and datapath widths.
package cpu_mul_pkg;

    localparam int XLEN  = 32;
    localparam int HALF  = 16;
    localparam int ACC_W = 49;

    localparam logic [1:0] OP_MUL    = 2'd0;
    localparam logic [1:0] OP_MULXUU = 2'd1;
    localparam logic [1:0] OP_MULXSU = 2'd2;
    localparam logic [1:0] OP_MULXSS = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_COL1  = 3'd2,
        ST_COL2  = 3'd3,
        ST_DONE  = 3'd4
    } mul_state_t;

endpackage

// File: rtl/cpu_mul_combine.sv
// Partial-product recombination: builds the 49-bit low accumulator from the
// first pass and the sign-corrected high word from the second pass.
import cpu_mul_pkg::*;

module cpu_mul_combine (
    input  logic [XLEN-1:0]  p1,
    input  logic [XLEN-1:0]  p2,
    input  logic [XLEN-1:0]  p3,
    input  logic [HALF:0]    acc_hi,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    input  logic [1:0]       op,
    output logic [ACC_W-1:0] acc_next,
    output logic [XLEN-1:0]  hi_word
);

    logic [XLEN:0] mid;

    // Sum the cross products, fold them into the low product, then correct
    // the unsigned high word for whichever operands are treated as signed.
    always_comb begin
        mid      = {1'b0, p2} + {1'b0, p3};
        acc_next = {{(ACC_W-XLEN){1'b0}}, p1} + {mid, {HALF{1'b0}}};
        hi_word  = p1 + {{(XLEN-HALF-1){1'b0}}, acc_hi};
        case (op)
            OP_MULXSS: begin
                if (a[XLEN-1]) hi_word = hi_word - b;
                if (b[XLEN-1]) hi_word = hi_word - a;
            end
            OP_MULXSU: begin
                if (a[XLEN-1]) hi_word = hi_word - b;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_mul_seq.sv
// Multiply sequencer: drives the 16x16 three-product cell for one or two
// passes and recombines the products into the low or high result word.
import cpu_mul_pkg::*;

module cpu_mul_seq (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            ready,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [XLEN-1:0] mul_src1,
    output logic [XLEN-1:0] mul_src2,
    output logic            mul_en,
    input  logic [XLEN-1:0] mul_p1,
    input  logic [XLEN-1:0] mul_p2,
    input  logic [XLEN-1:0] mul_p3
);

    mul_state_t       state;
    logic [XLEN-1:0]  a_q;
    logic [XLEN-1:0]  b_q;
    logic [1:0]       op_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_next;
    logic [XLEN-1:0]  hi_word;

    assign ready = (state == ST_IDLE) || (state == ST_DONE);
    assign done  = (state == ST_DONE);

    cpu_mul_combine u_combine (
        .p1       (mul_p1),
        .p2       (mul_p2),
        .p3       (mul_p3),
        .acc_hi   (acc_q[ACC_W-1:XLEN]),
        .a        (a_q),
        .b        (b_q),
        .op       (op_q),
        .acc_next (acc_next),
        .hi_word  (hi_word)
    );

    // Cell operands: full operands on the first pass, the two high halves on
    // the second pass, and zero otherwise so the cell keeps its products.
    always_comb begin
        mul_en   = 1'b0;
        mul_src1 = '0;
        mul_src2 = '0;
        if (state == ST_ISSUE) begin
            mul_en   = 1'b1;
            mul_src1 = a_q;
            mul_src2 = b_q;
        end else if (state == ST_COL1 && op_q != OP_MUL) begin
            mul_en   = 1'b1;
            mul_src1 = {{HALF{1'b0}}, a_q[XLEN-1:HALF]};
            mul_src2 = {{HALF{1'b0}}, b_q[XLEN-1:HALF]};
        end
    end

    // Sequencer state and datapath registers; flush abandons the operation
    // without touching the last delivered result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= OP_MUL;
            acc_q  <= '0;
            result <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start && !flush) begin
                        a_q   <= src1;
                        b_q   <= src2;
                        op_q  <= op;
                        state <= ST_ISSUE;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    state <= flush ? ST_IDLE : ST_COL1;
                end
                ST_COL1: begin
                    if (flush) begin
                        state <= ST_IDLE;
                    end else begin
                        acc_q <= acc_next;
                        if (op_q == OP_MUL) begin
                            result <= acc_next[XLEN-1:0];
                            state  <= ST_DONE;
                        end else begin
                            state <= ST_COL2;
                        end
                    end
                end
                ST_COL2: begin
                    if (flush) begin
                        state <= ST_IDLE;
                    end else begin
                        result <= hi_word;
                        state  <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_mul_seq.sv
// Scoreboard bench for cpu_mul_seq with a behavioural three-product cell.
module tb_cpu_mul_seq;

    localparam logic [1:0] T_MUL    = 2'd0;
    localparam logic [1:0] T_MULXUU = 2'd1;
    localparam logic [1:0] T_MULXSU = 2'd2;
    localparam logic [1:0] T_MULXSS = 2'd3;

    typedef struct {
        logic [31:0] res;
        int          cycle;
        string       name;
    } expect_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] src1 = '0;
    logic [31:0] src2 = '0;
    logic        flush = 1'b0;
    logic        ready;
    logic        done;
    logic [31:0] result;
    logic [31:0] mul_src1;
    logic [31:0] mul_src2;
    logic        mul_en;
    logic [31:0] mul_p1 = '0;
    logic [31:0] mul_p2 = '0;
    logic [31:0] mul_p3 = '0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    expect_t sb[$];
    logic [31:0] prevResult;

    cpu_mul_seq dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .op       (op),
        .src1     (src1),
        .src2     (src2),
        .flush    (flush),
        .ready    (ready),
        .done     (done),
        .result   (result),
        .mul_src1 (mul_src1),
        .mul_src2 (mul_src2),
        .mul_en   (mul_en),
        .mul_p1   (mul_p1),
        .mul_p2   (mul_p2),
        .mul_p3   (mul_p3)
    );

    always #5 clk = ~clk;

    // Cycle counter, read on the falling edge
    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier cell: one-cycle registered products, gated by mul_en
    always @(posedge clk) begin
        if (mul_en) begin
            mul_p1 <= 32'(mul_src1[15:0]) * 32'(mul_src2[15:0]);
            mul_p2 <= 32'(mul_src1[15:0]) * 32'(mul_src2[31:16]);
            mul_p3 <= 32'(mul_src1[31:16]) * 32'(mul_src2[15:0]);
        end
    end

    task automatic checkOutput(input string nm, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", nm, actual, expected);
        end
    endtask

    // Monitor: every done pops the oldest expectation and checks value and timing
    always @(negedge clk) begin
        if (reset_n && done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_done at cycle %0d: got result 0x%08h expected no done", cyc, result);
            end else begin
                expect_t e;
                e = sb.pop_front();
                checkOutput({e.name, "_result"}, result, e.res);
                checkOutput({e.name, "_cycle"}, 32'(cyc), 32'(e.cycle));
            end
        end
    end

    // Waits for ready, issues one request and optionally records the expected result
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] s1, input logic [31:0] s2,
                                 input logic [31:0] exp, input bit expectDone, input string nm);
        int budget;
        budget = 0;
        @(negedge clk);
        while (!ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (!ready) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s_ready_timeout: got ready=0 expected ready=1", nm);
        end
        start = 1'b1;
        op    = o;
        src1  = s1;
        src2  = s2;
        if (expectDone) sb.push_back('{exp, cyc + ((o == T_MUL) ? 3 : 4), nm});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDrain(input string nm);
        int budget;
        budget = 0;
        while (sb.size() != 0 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        checkOutput({nm, "_drained"}, 32'(sb.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #12;
        checkOutput("reset_ready", 32'(ready), 32'd1);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_result", result, 32'h0);
        checkOutput("reset_mul_en", 32'(mul_en), 32'd0);
        checkOutput("reset_mul_src1", mul_src1, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        applyStimulus(T_MUL, 32'h00010003, 32'h00020005, 32'h000B000F, 1'b1, "mul_basic");
        checkOutput("mul_ready_c1", 32'(ready), 32'd0);
        @(negedge clk);
        checkOutput("mul_ready_c2", 32'(ready), 32'd0);
        waitDrain("mul_basic");

        applyStimulus(T_MULXUU, 32'h00010003, 32'h00020005, 32'h00000002, 1'b1, "mulxuu_small");
        waitDrain("mulxuu_small");
        applyStimulus(T_MULXUU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, "mulxuu_max");
        waitDrain("mulxuu_max");
        applyStimulus(T_MULXSS, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, "mulxss_m1");
        waitDrain("mulxss_m1");
        applyStimulus(T_MULXSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, "mulxsu_m1");
        waitDrain("mulxsu_m1");
        applyStimulus(T_MULXSS, 32'h80000000, 32'h80000000, 32'h40000000, 1'b1, "mulxss_min");
        waitDrain("mulxss_min");

        // Back-to-back: start held through the MUL, MULXUU presented in its DONE cycle
        @(negedge clk);
        start = 1'b1;
        op    = T_MUL;
        src1  = 32'h00001234;
        src2  = 32'h00000010;
        sb.push_back('{32'h00012340, cyc + 3, "b2b_mul"});
        repeat (3) @(negedge clk);
        checkOutput("b2b_ready_in_done", 32'(ready), 32'd1);
        op   = T_MULXUU;
        src1 = 32'h12345678;
        src2 = 32'h00000100;
        sb.push_back('{32'h00000012, cyc + 4, "b2b_mulxuu"});
        @(negedge clk);
        start = 1'b0;
        waitDrain("b2b");

        // Flush in COL1 of a MULXUU
        prevResult = result;
        applyStimulus(T_MULXUU, 32'hDEADBEEF, 32'h01234567, 32'h0, 1'b0, "flush_op");
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flush_idle_ready", 32'(ready), 32'd1);
        checkOutput("flush_no_done", 32'(done), 32'd0);
        checkOutput("flush_result_kept", result, prevResult);
        repeat (3) @(negedge clk);
        applyStimulus(T_MUL, 32'h00000100, 32'h00000200, 32'h00020000, 1'b1, "post_flush_mul");
        waitDrain("post_flush_mul");

        // Asynchronous reset while in COL2
        applyStimulus(T_MULXUU, 32'hFFFFFFFF, 32'h00000003, 32'h0, 1'b0, "reset_op");
        @(negedge clk);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_rst_ready", 32'(ready), 32'd1);
        checkOutput("async_rst_done", 32'(done), 32'd0);
        checkOutput("async_rst_result", result, 32'h0);
        checkOutput("async_rst_mul_en", 32'(mul_en), 32'd0);
        checkOutput("async_rst_mul_src2", mul_src2, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        applyStimulus(T_MUL, 32'd3, 32'd7, 32'd21, 1'b1, "post_reset_mul");
        waitDrain("post_reset_mul");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
